upsample_read_controller: RTL and testbench
===========================================

Name: upsample_read_controller

Overview:
- Drains the 2x upsample buffer FIFO (write 16-bit, read 8-bit, virtual/real read pointers) and sits directly downstream of it.
- Replays each buffered input row twice: first pass on the virtual pointer, second pass on the real pointer, so rows are duplicated vertically.
- Emits every pixel twice in a row, so pixels are duplicated horizontally.
- Drives a valid/ready pixel stream towards the next layer's input stage.

Parameters:
- DATA_R, 8, pixel width; equals the FIFO read width.
- DEPTH_R, 11, FIFO read-address width; also the width of row_length.
- ROWS_W, 10, width of the per-frame input-row count.

Ports:
- system_clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches row_length and frame_rows, begins a frame.
- row_length  in  DEPTH_R  input pixels per row; legal range 2..READ_NUM/2, even.
- frame_rows  in  ROWS_W  input rows per frame; legal value ≥1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last output pixel is accepted.
- fifo_rden  out  1  FIFO read enable.
- fifo_rddata  in  DATA_R  FIFO read data; valid the cycle after fifo_rden.
- fifo_empty  in  1  FIFO o_empty.
- fifo_hold  in  1  FIFO ready_for_output; high means stall.
- fifo_change_point  out  1  one-cycle pulse that toggles the FIFO pointer select.
- fifo_ae_threshold  out  DEPTH_R  drives almost_empty_threshold; equals the latched row_length.
- out_data  out  DATA_R  upsampled pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, counters clear, holding register empty, internal pointer-mode tracker = 0 (virtual, matching the FIFO reset).
- FSM states: IDLE, WAIT_ROW, PASS0, SWITCH0, PASS1, SWITCH1, DONE.
- IDLE:
  - start latches the parameters and moves to WAIT_ROW.
  - start while busy is ignored.
- WAIT_ROW:
  - Pointer mode is virtual, so fifo_hold means "fewer than row_length pixels buffered".
  - Stay while fifo_hold=1.
  - Move to PASS0 on the first cycle fifo_hold=0.
- PASS0 / PASS1:
  - Issue exactly row_length reads, at most one outstanding.
  - fifo_rden is asserted only when the holding register will be free next cycle: it is empty and no read is in flight, or out_valid & out_ready on the second copy.
  - fifo_rden must never be asserted while fifo_empty=1.
  - The returned word is captured into the holding register the cycle after fifo_rden.
  - out_valid rises in the capture cycle.
  - Each held pixel is presented twice: copy 0, then copy 1. It advances only on out_valid & out_ready.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - The state exits once the last pixel's copy 1 is accepted.
- SWITCH0:
  - Pulse fifo_change_point for 1 cycle, then go to PASS1. The mode is now real.
  - PASS1 re-reads the same row_length pixels and advances the real pointer.
- SWITCH1:
  - Pulse fifo_change_point for 1 cycle; mode returns to virtual.
  - Increment the row counter.
  - If row counter == frame_rows, go to DONE; otherwise go to WAIT_ROW.
- DONE: pulse done for 1 cycle, then go to IDLE. busy falls in the same cycle done pulses.
- Output count per frame: exactly 4 × row_length × frame_rows pixels.
- Latency: first out_valid appears 2 cycles after WAIT_ROW sees fifo_hold=0 (1 cycle in PASS0 to issue the read, 1 cycle for RAM return).
- Throughput: with out_ready held at 1, one pixel per cycle in steady state, with no bubble between read pixels.
- Mode consistency: change_point pulses strictly alternate, and the mode is always virtual in IDLE and WAIT_ROW.
- Arithmetic:
  - Pixel counter is DEPTH_R bits, compared against row_length - 1.
  - Row counter is ROWS_W bits, compared after increment.
  - There is no wrap beyond the legal range.
- Reset mid-frame:
  - All state clears immediately.
  - The FIFO must be reset concurrently, otherwise its pointer select may be left in real mode.

Decomposition:
- Shared package / parameters.v:
  - FSM state encodings: UPS_IDLE..UPS_DONE, 3 bits.
  - UPS_COPIES = 2.
  - Default DATA_R/DEPTH_R, the same constants as the buffer.
- One natural sub-module: upsample_pixel_dup.
  - Contains the holding register, the copy toggle and the valid/ready logic.
  - Exposes load/free handshakes to the FSM.

Test Plan:
- Single frame, row_length=4, frame_rows=1, FIFO preloaded with pixels 1..4, out_ready=1 → output 1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4; exactly 2 change_point pulses; done pulses once; busy low afterwards.
- row_length=8, fifo_hold held at 1 for 20 cycles after start → no fifo_rden and no out_valid during the hold; first out_valid 2 cycles after fifo_hold falls.
- Backpressure: out_ready toggles 1/0 on alternate cycles, row_length=4 → out_data stable whenever out_ready=0; no pixel lost or duplicated beyond 2x; 16 accepted pixels.
- frame_rows=3, row_length=6, rows written in bursts with gaps → 72 output pixels; 6 change_point pulses; mode back at virtual; FIFO empty at done.
- Reset asserted in the middle of PASS1 → all outputs 0 in the same cycle; after release, start works normally and a fresh frame yields the correct sequence.
- start pulsed again while busy → ignored; pixel and row counts unchanged.

Source files
------------

// File: rtl/upsample_read_controller_pkg.sv
// Shared constants and encodings for the 2x upsample read controller.
// Pixel and address widths match the upsample buffer FIFO read side.
package upsample_read_controller_pkg;

  localparam int unsigned DATA_R     = 8;
  localparam int unsigned DEPTH_R    = 11;
  localparam int unsigned ROWS_W     = 10;
  localparam int unsigned UPS_COPIES = 2;

  typedef enum logic [2:0] {
    UPS_IDLE     = 3'd0,
    UPS_WAIT_ROW = 3'd1,
    UPS_PASS0    = 3'd2,
    UPS_SWITCH0  = 3'd3,
    UPS_PASS1    = 3'd4,
    UPS_SWITCH1  = 3'd5,
    UPS_DONE     = 3'd6
  } ups_state_e;

  // FIFO pointer select; the FIFO resets into virtual mode
  typedef enum logic {
    PTR_VIRTUAL = 1'b0,
    PTR_REAL    = 1'b1
  } ptr_mode_e;

endpackage

// File: rtl/upsample_read_controller_if.sv
// Valid/ready pixel stream from the upsample controller to the next layer.
interface upsample_read_controller_if #(
  parameter int unsigned DATA_R = upsample_read_controller_pkg::DATA_R
);
  logic [DATA_R-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/upsample_read_controller_pixel_dup.sv
// Holding register that presents each fetched pixel UPS_COPIES times on the stream.
// The word is shown straight from the FIFO in its return cycle so reads run bubble-free.
module upsample_pixel_dup #(
  parameter int unsigned DATA_R = upsample_read_controller_pkg::DATA_R
) (
  input  logic              system_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_R-1:0] fifo_rddata,
  output logic              free_c,
  output logic              pair_done_c,
  upsample_read_controller_if.master px
);
  import upsample_read_controller_pkg::*;

  localparam logic LAST_COPY = 1'(UPS_COPIES - 1);

  logic              inflight_q;
  logic              full_q;
  logic              copy_q;
  logic [DATA_R-1:0] hold_q;
  logic              accept_c;

  assign px.out_valid = inflight_q | full_q;
  assign px.out_data  = inflight_q ? fifo_rddata : hold_q;
  assign accept_c     = px.out_valid & px.out_ready;
  assign pair_done_c  = accept_c & (copy_q == LAST_COPY);
  // A new read may issue when the register will be empty next cycle
  assign free_c       = (!inflight_q && !full_q) || pair_done_c;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      full_q     <= 1'b0;
      copy_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      inflight_q <= load;
      if (inflight_q) begin
        hold_q <= fifo_rddata;
        full_q <= 1'b1;
      end else if (pair_done_c) begin
        full_q <= 1'b0;
      end
      if (pair_done_c) begin
        copy_q <= 1'b0;
      end else if (accept_c) begin
        copy_q <= copy_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/upsample_read_controller.sv
// Drains the 2x upsample FIFO: each row is replayed on the virtual then the real
// pointer, and each pixel is emitted twice, giving 2x vertical and horizontal upsampling.
module upsample_read_controller #(
  parameter int unsigned DATA_R  = upsample_read_controller_pkg::DATA_R,
  parameter int unsigned DEPTH_R = upsample_read_controller_pkg::DEPTH_R,
  parameter int unsigned ROWS_W  = upsample_read_controller_pkg::ROWS_W
) (
  input  logic               system_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DEPTH_R-1:0] row_length,
  input  logic [ROWS_W-1:0]  frame_rows,
  output logic               busy,
  output logic               done,
  output logic               fifo_rden,
  input  logic [DATA_R-1:0]  fifo_rddata,
  input  logic               fifo_empty,
  input  logic               fifo_hold,
  output logic               fifo_change_point,
  output logic [DEPTH_R-1:0] fifo_ae_threshold,
  upsample_read_controller_if.master px
);
  import upsample_read_controller_pkg::*;

  ups_state_e         state_q, state_d;
  ptr_mode_e          ptr_mode_q;
  logic [DEPTH_R-1:0] row_len_q;
  logic [DEPTH_R-1:0] pix_cnt_q;
  logic [ROWS_W-1:0]  frame_rows_q;
  logic [ROWS_W-1:0]  row_cnt_q;
  logic [ROWS_W-1:0]  row_cnt_inc_c;
  logic               in_pass_c;
  logic               last_pix_c;
  logic               pass_end_c;
  logic               free_c;
  logic               pair_done_c;
  logic               busy_d;
  logic               done_d;
  logic               change_d;

  // A pass only reads while the FIFO pointer select matches the pass
  assign in_pass_c     = ((state_q == UPS_PASS0) && (ptr_mode_q == PTR_VIRTUAL)) ||
                         ((state_q == UPS_PASS1) && (ptr_mode_q == PTR_REAL));
  assign last_pix_c    = (pix_cnt_q == row_len_q - DEPTH_R'(1));
  assign pass_end_c    = in_pass_c && pair_done_c && last_pix_c;
  assign row_cnt_inc_c = row_cnt_q + ROWS_W'(1);
  assign fifo_ae_threshold = row_len_q;

  upsample_pixel_dup #(.DATA_R(DATA_R)) u_dup (
    .system_clk  (system_clk),
    .rst         (rst),
    .load        (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .free_c      (free_c),
    .pair_done_c (pair_done_c),
    .px          (px)
  );

  // State register; status outputs are registered from the next state
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q           <= UPS_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      fifo_change_point <= 1'b0;
    end else begin
      state_q           <= state_d;
      busy              <= busy_d;
      done              <= done_d;
      fifo_change_point <= change_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UPS_IDLE:     if (start) state_d = UPS_WAIT_ROW;
      UPS_WAIT_ROW: if (!fifo_hold) state_d = UPS_PASS0;
      UPS_PASS0:    if (pass_end_c) state_d = UPS_SWITCH0;
      UPS_SWITCH0:  state_d = UPS_PASS1;
      UPS_PASS1:    if (pass_end_c) state_d = UPS_SWITCH1;
      UPS_SWITCH1:  state_d = (row_cnt_inc_c == frame_rows_q) ? UPS_DONE : UPS_WAIT_ROW;
      UPS_DONE:     state_d = UPS_IDLE;
      default:      state_d = UPS_IDLE;
    endcase
  end

  always_comb begin
    fifo_rden = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    change_d  = 1'b0;
    if (in_pass_c && free_c && !fifo_empty && !pass_end_c) begin
      fifo_rden = 1'b1;
    end
    case (state_d)
      UPS_IDLE: busy_d = 1'b0;
      UPS_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      UPS_SWITCH0, UPS_SWITCH1: change_d = 1'b1;
      default: ;
    endcase
  end

  // Frame parameters, pixel/row counters and the FIFO pointer-mode tracker
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      row_len_q    <= '0;
      frame_rows_q <= '0;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      ptr_mode_q   <= PTR_VIRTUAL;
    end else begin
      if ((state_q == UPS_IDLE) && start) begin
        row_len_q    <= row_length;
        frame_rows_q <= frame_rows;
        row_cnt_q    <= '0;
      end
      if (pass_end_c) begin
        pix_cnt_q <= '0;
      end else if (in_pass_c && pair_done_c) begin
        pix_cnt_q <= pix_cnt_q + DEPTH_R'(1);
      end
      if ((state_q == UPS_SWITCH0) || (state_q == UPS_SWITCH1)) begin
        ptr_mode_q <= (ptr_mode_q == PTR_VIRTUAL) ? PTR_REAL : PTR_VIRTUAL;
      end
      if (state_q == UPS_SWITCH1) begin
        row_cnt_q <= row_cnt_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_upsample_read_controller.sv
// Scoreboard bench: a behavioural virtual/real-pointer FIFO feeds the controller and
// expected pixels are queued as rows are written, then popped by an output monitor.
module tb_upsample_read_controller;
  import upsample_read_controller_pkg::*;

  logic               system_clk = 1'b0;
  logic               rst;
  logic               start;
  logic [DEPTH_R-1:0] row_length;
  logic [ROWS_W-1:0]  frame_rows;
  logic               busy, done, fifo_rden, fifo_empty, fifo_hold, fifo_change_point;
  logic [DATA_R-1:0]  fifo_rddata;
  logic [DEPTH_R-1:0] fifo_ae_threshold;

  upsample_read_controller_if px ();

  upsample_read_controller dut (
    .system_clk        (system_clk),
    .rst               (rst),
    .start             (start),
    .row_length        (row_length),
    .frame_rows        (frame_rows),
    .busy              (busy),
    .done              (done),
    .fifo_rden         (fifo_rden),
    .fifo_rddata       (fifo_rddata),
    .fifo_empty        (fifo_empty),
    .fifo_hold         (fifo_hold),
    .fifo_change_point (fifo_change_point),
    .fifo_ae_threshold (fifo_ae_threshold),
    .px                (px)
  );

  always #5 system_clk = ~system_clk;

  // FIFO model: pixels appended at wr_ptr, read through the selected pointer
  logic [DATA_R-1:0] mem [0:4095];
  int   wr_ptr = 0;
  int   rd_virt, rd_real, avail;
  logic mode_real;
  bit   hold_force = 1'b0;

  assign avail      = wr_ptr - (mode_real ? rd_real : rd_virt);
  assign fifo_empty = (avail <= 0);
  assign fifo_hold  = hold_force || (!mode_real && (avail < int'(fifo_ae_threshold)));

  always @(posedge system_clk or posedge rst) begin
    if (rst) begin
      rd_virt     <= 0;
      rd_real     <= 0;
      mode_real   <= 1'b0;
      fifo_rddata <= '0;
    end else begin
      if (fifo_rden) begin
        if (mode_real) begin
          fifo_rddata <= mem[rd_real];
          rd_real     <= rd_real + 1;
        end else begin
          fifo_rddata <= mem[rd_virt];
          rd_virt     <= rd_virt + 1;
        end
      end
      if (fifo_change_point) begin
        mode_real <= !mode_real;
        if (mode_real) rd_virt <= rd_real;
      end
    end
  end

  int ready_mode = 0;
  always @(posedge system_clk) begin
    #1;
    case (ready_mode)
      0:       px.out_ready = 1'b1;
      1:       px.out_ready = ~px.out_ready;
      default: px.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int checks = 0, failures = 0;
  int n_acc = 0, n_cp = 0, n_done = 0, bad_rd = 0, hold_viol = 0;
  int acc0, cp0, done0;
  logic [DATA_R-1:0] exp_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  bit                prev_stall = 1'b0;
  logic [DATA_R-1:0] prev_data;
  always @(negedge system_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", px.out_valid, 1);
        check("stall_data", px.out_data, prev_data);
      end
      if (px.out_valid && px.out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel actual=%0d required=none", px.out_data);
        end else begin
          check("pixel", px.out_data, exp_q.pop_front());
        end
      end
      prev_stall = px.out_valid && !px.out_ready;
      prev_data  = px.out_data;
      if (fifo_change_point) n_cp++;
      if (done) begin
        n_done++;
        check("busy_at_done", busy, 0);
      end
      if (fifo_rden && fifo_empty) bad_rd++;
      if (hold_force && (fifo_rden || px.out_valid)) hold_viol++;
    end
  end

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  // Expected stream for a row: two passes over the row, every pixel twice
  task automatic write_row(input int len, input bit bursty, input bit seq);
    logic [DATA_R-1:0] row[$];
    for (int i = 0; i < len; i++) row.push_back(seq ? DATA_R'(i + 1) : DATA_R'($urandom));
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < len; i++)
        for (int c = 0; c < 2; c++) exp_q.push_back(row[i]);
    for (int i = 0; i < len; i++) begin
      if (bursty) repeat ($urandom_range(0, 2)) tick();
      mem[wr_ptr] = row[i];
      wr_ptr++;
    end
  endtask

  task automatic write_rows(input int len, input int rows);
    for (int r = 0; r < rows; r++) begin
      repeat ($urandom_range(0, 12)) tick();
      write_row(len, 1'b1, 1'b0);
    end
  endtask

  task automatic start_frame(input int len, input int rows);
    acc0       = n_acc;
    cp0        = n_cp;
    done0      = n_done;
    row_length = DEPTH_R'(len);
    frame_rows = ROWS_W'(rows);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input int len, input int rows);
    int cyc = 0;
    while (n_done == done0 && cyc < 20000) begin
      @(negedge system_clk);
      cyc++;
    end
    repeat (3) tick();
    check("accepted_pixels", n_acc - acc0, 4 * len * rows);
    check("change_points", n_cp - cp0, 2 * rows);
    check("done_pulses", n_done - done0, 1);
    check("busy_after", busy, 0);
    check("leftover_expected", exp_q.size(), 0);
    check("mode_virtual", mode_real, 0);
    check("fifo_empty_at_end", fifo_empty, 1);
    check("ae_threshold", fifo_ae_threshold, len);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rden"}, fifo_rden, 0);
    check({tag, "_change_point"}, fifo_change_point, 0);
    check({tag, "_ae_threshold"}, fifo_ae_threshold, 0);
    check({tag, "_out_valid"}, px.out_valid, 0);
    check({tag, "_out_data"}, px.out_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, len, rows;
    rst        = 1'b1;
    start      = 1'b0;
    row_length = '0;
    frame_rows = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Single row, sequential pixels, full throughput
    ready_mode = 0;
    write_row(4, 1'b0, 1'b1);
    start_frame(4, 1);
    finish_frame(4, 1);

    // Held FIFO: nothing moves until hold falls, then 2-cycle latency
    write_row(8, 1'b0, 1'b0);
    hold_force = 1'b1;
    start_frame(8, 1);
    repeat (20) tick();
    hold_force = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge system_clk);
      if (px.out_valid) break;
      k++;
    end
    check("hold_violations", hold_viol, 0);
    check("first_valid_latency", k, 2);
    finish_frame(8, 1);

    // Alternating backpressure
    ready_mode = 1;
    write_row(4, 1'b0, 1'b0);
    start_frame(4, 1);
    finish_frame(4, 1);

    // Three rows written in bursts with gaps, random backpressure
    ready_mode = 2;
    start_frame(6, 3);
    fork
      write_rows(6, 3);
      finish_frame(6, 3);
    join

    // A second start while busy is ignored
    ready_mode = 0;
    write_row(4, 1'b0, 1'b0);
    write_row(4, 1'b0, 1'b0);
    start_frame(4, 2);
    fork
      begin
        repeat (12) tick();
        row_length = DEPTH_R'(2);
        frame_rows = ROWS_W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      finish_frame(4, 2);
    join

    // Reset in the middle of the real-pointer pass
    write_row(8, 1'b0, 1'b0);
    start_frame(8, 1);
    cyc = 0;
    while (n_cp == cp0 && cyc < 2000) begin
      @(negedge system_clk);
      cyc++;
    end
    check("reached_pass1", n_cp - cp0, 1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    wr_ptr = 0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    write_row(4, 1'b0, 1'b1);
    write_row(4, 1'b0, 1'b0);
    start_frame(4, 2);
    finish_frame(4, 2);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      len        = 2 * $urandom_range(1, 8);
      rows       = $urandom_range(1, 3);
      ready_mode = $urandom_range(0, 2);
      start_frame(len, rows);
      fork
        write_rows(len, rows);
        finish_frame(len, rows);
      join
    end

    check("rden_while_empty", bad_rd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
